// File: rtl/util_1553_pack_pkg.sv
// Shared types and constants for the 1553-word to UART byte packer.
// UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN adds the trailing XOR checksum state.
package util_1553_pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DHI,
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
    ST_DLO,
    ST_CHK
`else
    ST_DLO
`endif
  } state_t;

  localparam logic [1:0] SYNC_CMD_STAT = 2'b01;
  localparam logic [1:0] SYNC_DATA     = 2'b10;

  localparam logic [2:0] DEFAULT_HEADER_MARKER = 3'b101;

  localparam int FRAME_LEN_BASE = 3;
  localparam int FRAME_LEN_CHK  = 4;

`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
  localparam int     FRAME_LEN  = FRAME_LEN_CHK;
  localparam state_t LAST_STATE = ST_CHK;
`else
  localparam int     FRAME_LEN  = FRAME_LEN_BASE;
  localparam state_t LAST_STATE = ST_DLO;
`endif

  function automatic logic is_valid_sync(input logic [1:0] sync);
    return (sync == SYNC_CMD_STAT) || (sync == SYNC_DATA);
  endfunction

  // Invalid sync types that are forwarded carry type code 00 in the header.
  function automatic logic [7:0] make_header(input logic [2:0] marker, input logic [2:0] tuser);
    logic [1:0] code;
    code = is_valid_sync(tuser[1:0]) ? tuser[1:0] : 2'b00;
    return {marker, tuser[2], 2'b00, code};
  endfunction

endpackage

// File: rtl/util_1553_word_to_uart_pack.sv
// Serializes one decoded 1553 word per AXIS beat into a header/data-hi/data-lo byte frame.
// Defining UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN appends an XOR checksum byte.
module util_1553_word_to_uart_pack
  import util_1553_pack_pkg::*;
#(
  parameter logic [2:0] header_marker = DEFAULT_HEADER_MARKER,
  parameter bit         drop_invalid  = 1'b1
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic [2:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  drop_count
);

  state_t      state_reg, state_next;
  logic [15:0] data_reg, data_next;
  logic [7:0]  tdata_reg, tdata_next;
  logic        tvalid_reg, tvalid_next;
  logic [7:0]  drop_count_reg;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
  logic [7:0]  hdr_reg, hdr_next;
`endif

  logic       accept, drop, frame_start, handshake;
  logic [7:0] new_hdr;

  // Ready is gated by reset so no word is taken while arstn is low.
  assign s_axis_tready = arstn & ((state_reg == ST_IDLE) ||
                                  ((state_reg == LAST_STATE) && m_axis_tready));
  assign accept      = s_axis_tvalid & s_axis_tready;
  assign drop        = accept & drop_invalid & ~is_valid_sync(s_axis_tuser[1:0]);
  assign frame_start = accept & ~drop;
  assign handshake   = tvalid_reg & m_axis_tready;
  assign new_hdr     = make_header(header_marker, s_axis_tuser);

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    tdata_next  = tdata_reg;
    tvalid_next = tvalid_reg;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
    hdr_next    = hdr_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          state_next  = ST_HDR;
          data_next   = s_axis_tdata;
          tdata_next  = new_hdr;
          tvalid_next = 1'b1;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
          hdr_next    = new_hdr;
`endif
        end
      end
      ST_HDR: begin
        if (handshake) begin
          state_next = ST_DHI;
          tdata_next = data_reg[15:8];
        end
      end
      ST_DHI: begin
        if (handshake) begin
          state_next = ST_DLO;
          tdata_next = data_reg[7:0];
        end
      end
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
      ST_DLO: begin
        if (handshake) begin
          state_next = ST_CHK;
          tdata_next = hdr_reg ^ data_reg[15:8] ^ data_reg[7:0];
        end
      end
      ST_CHK: begin
`else
      ST_DLO: begin
`endif
        // Last byte: chain straight into the next frame when a word arrives.
        if (handshake) begin
          if (frame_start) begin
            state_next  = ST_HDR;
            data_next   = s_axis_tdata;
            tdata_next  = new_hdr;
            tvalid_next = 1'b1;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
            hdr_next    = new_hdr;
`endif
          end else begin
            state_next  = ST_IDLE;
            tvalid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        tvalid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_reg      <= ST_IDLE;
      data_reg       <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      drop_count_reg <= '0;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
      hdr_reg        <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      tdata_reg  <= tdata_next;
      tvalid_reg <= tvalid_next;
`ifdef UTIL_1553_WORD_TO_UART_PACK_CHKSUM_EN
      hdr_reg    <= hdr_next;
`endif
      if (drop && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign drop_count    = drop_count_reg;

endmodule
